// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART RX read/error path: FIFO entry bit layout,
// sticky status bit positions and the read sequencer state encoding.
package uart_rx_pkg;

    localparam int DATA_W  = 8;
    localparam int ENTRY_W = 12;

    // FIFO entry layout
    localparam int PAR_BIT = 8;
    localparam int OE_BIT  = 9;
    localparam int BE_BIT  = 10;
    localparam int FE_BIT  = 11;

    // sts bit positions
    localparam int STS_OE = 0;
    localparam int STS_BE = 1;
    localparam int STS_FE = 2;
    localparam int STS_UF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAP  = 2'd2,
        RESP = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_err_ctrl_if.sv
// Host read bus between the APB register slave (master) and the RX read
// sequencer (slave): request pulse in, byte + error flag + strobe out.
interface uart_rx_err_ctrl_if;
   logic       rd_req;
   logic       rd_valid;
   logic [7:0] rd_data;
   logic       rd_err;

   modport master (output rd_req, input rd_valid, input rd_data, input rd_err);
   modport slave  (input rd_req, output rd_valid, output rd_data, output rd_err);
endinterface

// File: rtl/uart_err_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment so a coincident event is discarded.
module uart_err_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_reg;
   logic [W-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && (cnt_reg != {W{1'b1}})) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/uart_rx_err_ctrl.sv
// RX FIFO read sequencer with sticky OE/BE/FE/UF status, W1C clear and masked irq.
// Define UART_RX_ERR_CNT_EN to add per-error saturating counters (err_cnt, cnt_clr).
module uart_rx_err_ctrl
   import uart_rx_pkg::*;
`ifdef UART_RX_ERR_CNT_EN
#(
   parameter int CNT_W = 8
)
`endif
(
   input  logic                 clk,
   input  logic                 rst,
   uart_rx_err_ctrl_if.slave    host,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [ENTRY_W-1:0]   fifo_rdata,
   output logic [3:0]           sts,
   input  logic [3:0]           sts_clr,
   input  logic [3:0]           irq_mask,
   output logic                 irq
`ifdef UART_RX_ERR_CNT_EN
   ,
   output logic [3*CNT_W-1:0]   err_cnt,
   input  logic                 cnt_clr
`endif
);

   rx_state_e          state_reg, state_next;
   logic [DATA_W-1:0]  rd_data_reg, rd_data_next;
   logic               rd_err_reg, rd_err_next;
   logic [3:0]         sts_reg, sts_next;
   logic               irq_reg, irq_next;
   logic [3:0]         set_bits;
   logic [2:0]         err_bits;
   logic               unused_parity;

   // err_bits[0..2] line up with both sts[OE..FE] and the counter order
   assign err_bits      = {fifo_rdata[FE_BIT], fifo_rdata[BE_BIT], fifo_rdata[OE_BIT]};
   assign unused_parity = fifo_rdata[PAR_BIT];

   always_comb begin
      state_next   = state_reg;
      rd_data_next = rd_data_reg;
      rd_err_next  = rd_err_reg;
      set_bits     = '0;
      case (state_reg)
         IDLE: begin
            if (host.rd_req) begin
               if (fifo_empty) begin
                  state_next       = RESP;
                  rd_data_next     = '0;
                  rd_err_next      = 1'b1;
                  set_bits[STS_UF] = 1'b1;
               end else begin
                  state_next = POP;
               end
            end
         end
         POP: begin
            state_next = CAP;
         end
         CAP: begin
            rd_data_next     = fifo_rdata[DATA_W-1:0];
            rd_err_next      = |err_bits;
            set_bits[STS_OE] = err_bits[0];
            set_bits[STS_BE] = err_bits[1];
            set_bits[STS_FE] = err_bits[2];
            state_next       = RESP;
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // a set event in the same cycle as its clear leaves the bit set
      sts_next = (sts_reg & ~sts_clr) | set_bits;
      irq_next = |(sts_reg & irq_mask);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= IDLE;
         rd_data_reg <= '0;
         rd_err_reg  <= 1'b0;
         sts_reg     <= '0;
         irq_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         rd_data_reg <= rd_data_next;
         rd_err_reg  <= rd_err_next;
         sts_reg     <= sts_next;
         irq_reg     <= irq_next;
      end
   end

   assign host.rd_valid = (state_reg == RESP);
   assign host.rd_data  = rd_data_reg;
   assign host.rd_err   = rd_err_reg;
   assign fifo_rd_en    = (state_reg == POP);
   assign sts           = sts_reg;
   assign irq           = irq_reg;

`ifdef UART_RX_ERR_CNT_EN
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         uart_err_sat_cnt #(
            .W (CNT_W)
         ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc ((state_reg == CAP) && err_bits[gi]),
            .clr (cnt_clr),
            .cnt (err_cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate
`endif

endmodule

// File: tb/tb_uart_rx_err_ctrl.sv
// Directed bench for uart_rx_err_ctrl: read timing, error flags, sticky status,
// irq latency, underflow, set-wins, dropped requests, mid-read reset and counters.
module tb_uart_rx_err_ctrl;

   logic        clk;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [11:0] fifo_rdata;
   logic [3:0]  sts;
   logic [3:0]  sts_clr;
   logic [3:0]  irq_mask;
   logic        irq;
`ifdef UART_RX_ERR_CNT_EN
   logic [5:0]  err_cnt;
   logic        cnt_clr;
`endif

   int checks   = 0;
   int failures = 0;

   uart_rx_err_ctrl_if host_if ();

`ifdef UART_RX_ERR_CNT_EN
   uart_rx_err_ctrl #(.CNT_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .host       (host_if),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .sts        (sts),
      .sts_clr    (sts_clr),
      .irq_mask   (irq_mask),
      .irq        (irq),
      .err_cnt    (err_cnt),
      .cnt_clr    (cnt_clr)
   );
`else
   uart_rx_err_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .host       (host_if),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .sts        (sts),
      .sts_clr    (sts_clr),
      .irq_mask   (irq_mask),
      .irq        (irq)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge (start of next cycle)
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue a read and stop in the RESP cycle
   task automatic do_read(input logic [11:0] entry, input logic empty);
      fifo_rdata     = entry;
      fifo_empty     = empty;
      host_if.rd_req = 1'b1;
      next_cycle();
      host_if.rd_req = 1'b0;
      if (!empty) repeat (2) next_cycle();
      $display("read entry=%h empty=%b -> valid=%b data=%h err=%b sts=%b",
               entry, empty, host_if.rd_valid, host_if.rd_data, host_if.rd_err, sts);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) next_cycle();
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", host_if.rd_valid); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (host_if.rd_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", host_if.rd_data); end
      checks++; if (host_if.rd_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", host_if.rd_err); end
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL rst_sts got=%b exp=0000", sts); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b exp=0", irq); end
      rst = 1'b1;
      next_cycle();
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_valid got=%b exp=0", host_if.rd_valid); end
   endtask

   task automatic test_clean_read();
      fifo_empty     = 1'b0;
      fifo_rdata     = 12'h0A5;
      host_if.rd_req = 1'b1;
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL clean_c0_rd_en got=%b exp=0", fifo_rd_en); end
      next_cycle();
      host_if.rd_req = 1'b0;
      checks++; if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL clean_c1_rd_en got=%b exp=1", fifo_rd_en); end
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL clean_c1_valid got=%b exp=0", host_if.rd_valid); end
      next_cycle();
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL clean_c2_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL clean_c2_valid got=%b exp=0", host_if.rd_valid); end
      next_cycle();
      $display("read entry=0a5 -> valid=%b data=%h err=%b sts=%b", host_if.rd_valid, host_if.rd_data, host_if.rd_err, sts);
      checks++; if (host_if.rd_valid !== 1'b1) begin failures++; $display("FAIL clean_c3_valid got=%b exp=1", host_if.rd_valid); end
      checks++; if (host_if.rd_data !== 8'hA5) begin failures++; $display("FAIL clean_data got=%h exp=a5", host_if.rd_data); end
      checks++; if (host_if.rd_err !== 1'b0) begin failures++; $display("FAIL clean_err got=%b exp=0", host_if.rd_err); end
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL clean_sts got=%b exp=0000", sts); end
      next_cycle();
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL clean_c4_valid got=%b exp=0", host_if.rd_valid); end
      checks++; if (host_if.rd_data !== 8'hA5) begin failures++; $display("FAIL clean_hold_data got=%h exp=a5", host_if.rd_data); end
   endtask

   task automatic test_oe_irq();
      irq_mask = 4'b0001;
      do_read(12'h23C, 1'b0);
      checks++; if (host_if.rd_err !== 1'b1) begin failures++; $display("FAIL oe_err got=%b exp=1", host_if.rd_err); end
      checks++; if (host_if.rd_data !== 8'h3C) begin failures++; $display("FAIL oe_data got=%h exp=3c", host_if.rd_data); end
      checks++; if (sts !== 4'b0001) begin failures++; $display("FAIL oe_sts got=%b exp=0001", sts); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oe_irq_early got=%b exp=0", irq); end
      next_cycle();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oe_irq got=%b exp=1", irq); end
      sts_clr = 4'b0001;
      next_cycle();
      sts_clr = 4'b0000;
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL oe_clr_sts got=%b exp=0000", sts); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oe_irq_lag got=%b exp=1", irq); end
      next_cycle();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oe_irq_clr got=%b exp=0", irq); end
      irq_mask = 4'b0000;
   endtask

   task automatic test_underflow();
      fifo_empty     = 1'b1;
      host_if.rd_req = 1'b1;
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL uf_c0_rd_en got=%b exp=0", fifo_rd_en); end
      next_cycle();
      host_if.rd_req = 1'b0;
      $display("read empty -> valid=%b data=%h err=%b sts=%b", host_if.rd_valid, host_if.rd_data, host_if.rd_err, sts);
      checks++; if (host_if.rd_valid !== 1'b1) begin failures++; $display("FAIL uf_valid got=%b exp=1", host_if.rd_valid); end
      checks++; if (host_if.rd_err !== 1'b1) begin failures++; $display("FAIL uf_err got=%b exp=1", host_if.rd_err); end
      checks++; if (host_if.rd_data !== 8'h00) begin failures++; $display("FAIL uf_data got=%h exp=00", host_if.rd_data); end
      checks++; if (sts !== 4'b1000) begin failures++; $display("FAIL uf_sts got=%b exp=1000", sts); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL uf_c1_rd_en got=%b exp=0", fifo_rd_en); end
      next_cycle();
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL uf_c2_valid got=%b exp=0", host_if.rd_valid); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL uf_c2_rd_en got=%b exp=0", fifo_rd_en); end
      sts_clr = 4'b1000;
      next_cycle();
      sts_clr = 4'b0000;
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL uf_clr_sts got=%b exp=0000", sts); end
   endtask

   task automatic test_set_wins();
      fifo_empty     = 1'b0;
      fifo_rdata     = 12'h812;
      host_if.rd_req = 1'b1;
      next_cycle();
      host_if.rd_req = 1'b0;
      next_cycle();
      sts_clr = 4'b0100;
      next_cycle();
      sts_clr = 4'b0000;
      $display("read entry=812 clr=0100 in cap -> valid=%b data=%h err=%b sts=%b", host_if.rd_valid, host_if.rd_data, host_if.rd_err, sts);
      checks++; if (sts !== 4'b0100) begin failures++; $display("FAIL setwins_sts got=%b exp=0100", sts); end
      checks++; if (host_if.rd_err !== 1'b1) begin failures++; $display("FAIL setwins_err got=%b exp=1", host_if.rd_err); end
      checks++; if (host_if.rd_data !== 8'h12) begin failures++; $display("FAIL setwins_data got=%h exp=12", host_if.rd_data); end
      next_cycle();
      sts_clr = 4'b0100;
      next_cycle();
      sts_clr = 4'b0000;
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL setwins_clr got=%b exp=0000", sts); end
   endtask

   task automatic test_drop_req();
      fifo_empty     = 1'b0;
      fifo_rdata     = 12'h0E7;
      host_if.rd_req = 1'b1;
      repeat (3) next_cycle();
      host_if.rd_req = 1'b0;
      $display("read entry=0e7 req held -> valid=%b data=%h err=%b", host_if.rd_valid, host_if.rd_data, host_if.rd_err);
      checks++; if (host_if.rd_valid !== 1'b1) begin failures++; $display("FAIL drop_valid got=%b exp=1", host_if.rd_valid); end
      checks++; if (host_if.rd_data !== 8'hE7) begin failures++; $display("FAIL drop_data got=%h exp=e7", host_if.rd_data); end
      next_cycle();
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL drop_c4_rd_en got=%b exp=0", fifo_rd_en); end
      next_cycle();
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL drop_c5_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL drop_c5_valid got=%b exp=0", host_if.rd_valid); end
   endtask

   task automatic test_reset_mid_read();
      irq_mask       = 4'b1111;
      fifo_empty     = 1'b0;
      fifo_rdata     = 12'h4AA;
      host_if.rd_req = 1'b1;
      next_cycle();
      host_if.rd_req = 1'b0;
      next_cycle();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      $display("read entry=4aa reset in cap -> valid=%b data=%h err=%b sts=%b", host_if.rd_valid, host_if.rd_data, host_if.rd_err, sts);
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", host_if.rd_valid); end
      checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL midrst_rd_en got=%b exp=0", fifo_rd_en); end
      checks++; if (host_if.rd_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", host_if.rd_data); end
      checks++; if (host_if.rd_err !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", host_if.rd_err); end
      checks++; if (sts !== 4'b0000) begin failures++; $display("FAIL midrst_sts got=%b exp=0000", sts); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midrst_irq got=%b exp=0", irq); end
      next_cycle();
      checks++; if (host_if.rd_valid !== 1'b0) begin failures++; $display("FAIL midrst_c4_valid got=%b exp=0", host_if.rd_valid); end
      irq_mask = 4'b0000;
      do_read(12'h0C3, 1'b0);
      checks++; if (host_if.rd_valid !== 1'b1) begin failures++; $display("FAIL after_rst_valid got=%b exp=1", host_if.rd_valid); end
      checks++; if (host_if.rd_data !== 8'hC3) begin failures++; $display("FAIL after_rst_data got=%h exp=c3", host_if.rd_data); end
      checks++; if (host_if.rd_err !== 1'b0) begin failures++; $display("FAIL after_rst_err got=%b exp=0", host_if.rd_err); end
      next_cycle();
   endtask

`ifdef UART_RX_ERR_CNT_EN
   task automatic test_counters();
      for (int i = 0; i < 5; i++) begin
         do_read(12'h401 + 12'(i), 1'b0);
         next_cycle();
         if (i == 1) begin
            checks++; if (err_cnt !== 6'b00_10_00) begin failures++; $display("FAIL cnt_two got=%b exp=001000", err_cnt); end
         end
      end
      checks++; if (err_cnt !== 6'b00_11_00) begin failures++; $display("FAIL cnt_sat got=%b exp=001100", err_cnt); end
      checks++; if (sts !== 4'b0010) begin failures++; $display("FAIL cnt_sts got=%b exp=0010", sts); end
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      checks++; if (err_cnt !== 6'b00_00_00) begin failures++; $display("FAIL cnt_clr got=%b exp=000000", err_cnt); end
      fifo_rdata     = 12'h4FF;
      host_if.rd_req = 1'b1;
      next_cycle();
      host_if.rd_req = 1'b0;
      next_cycle();
      cnt_clr = 1'b1;
      next_cycle();
      cnt_clr = 1'b0;
      $display("read entry=4ff cnt_clr in cap -> valid=%b err_cnt=%b", host_if.rd_valid, err_cnt);
      checks++; if (err_cnt !== 6'b00_00_00) begin failures++; $display("FAIL cnt_clr_wins got=%b exp=000000", err_cnt); end
      next_cycle();
   endtask
`endif

   initial begin
      rst            = 1'b0;
      host_if.rd_req = 1'b0;
      fifo_empty     = 1'b1;
      fifo_rdata     = 12'h000;
      sts_clr        = 4'b0000;
      irq_mask       = 4'b0000;
`ifdef UART_RX_ERR_CNT_EN
      cnt_clr        = 1'b0;
`endif
      #1;
      test_reset();
      test_clean_read();
      test_oe_irq();
      test_underflow();
      test_set_wins();
      test_drop_req();
      test_reset_mid_read();
`ifdef UART_RX_ERR_CNT_EN
      test_counters();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
